button_debounce: RTL and testbench

//  Input-side conditioner for a board push-button: synchronises the raw pin, debounces it, and emits
//  a clean level plus one-cycle press, release and long-press pulses.

---
 rtl/button_debounce_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/button_debounce.sv | 147 ++++++++++++++
 tb/tb_button_debounce.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button conditioner: debounce state
// encoding, default board timing and a parameter legality helper.
package button_debounce_pkg;

    // Debounce FSM states; encoding is fixed so that other blocks can decode it.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Default board timing: 50 MHz clock, 20 ms debounce window, 1 s long press.
    localparam int CLK_HZ                = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES   = CLK_HZ / 50;
    localparam int DEF_LONG_PRESS_CYCLES = CLK_HZ;
    localparam int DEF_CNT_W             = 26;

    // Bits needed to hold the larger of the two cycle counts, inclusive.
    function automatic int cnt_width(input int deb_cycles, input int long_cycles);
        int max_cycles;
        max_cycles = (deb_cycles > long_cycles) ? deb_cycles : long_cycles;
        return $clog2(max_cycles + 1);
    endfunction

    // A configuration is usable only if the debounce window is at least two
    // cycles, a long press is strictly longer than the debounce window, and
    // the counters are wide enough to reach the long-press saturation value.
    function automatic bit params_legal(input int deb_cycles, input int long_cycles,
                                        input int width);
        return (deb_cycles >= 2) &&
               (long_cycles > deb_cycles) &&
               (width >= cnt_width(deb_cycles, long_cycles)) &&
               (width <= 31);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit. The reset value
// is a parameter so the chain can be parked at the pin's idle level and no
// false edge appears when reset is released.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] stage_reg;

    // Shift the raw input through two flops; stage 1 is the metastability catcher.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= {2{RESET_VAL}};
        end else begin
            stage_reg <= {stage_reg[0], d};
        end
    end

    assign q = stage_reg[1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronises the raw pin, normalises polarity,
// debounces both edges and produces a clean held level plus one-cycle
// press, release and long-press strobes. All outputs are registered.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter bit BUTTON_ACTIVE_LOW = 1'b1,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int CNT_W             = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    // Refuse to build with a debounce window shorter than two cycles, a long
    // press not longer than the debounce window, or counters that are too narrow.
    generate
        if (!params_legal(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, CNT_W)) begin : g_param_check
            $error("button_debounce: illegal DEBOUNCE_CYCLES/LONG_PRESS_CYCLES/CNT_W combination");
        end
    endgenerate

    // The counter holds the number of increments already done after the first
    // pressed sample, so the window closes when it is about to reach N-1.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 2);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             button_sync;
    logic             btn_s;

    btn_state_t       state_reg;
    logic [CNT_W-1:0] deb_cnt_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic             long_done_reg;
    logic             pressed_reg;
    logic             press_pulse_reg;
    logic             release_pulse_reg;
    logic             long_press_reg;

    // Sync chain idles at the released pin level so reset never looks like a press.
    sync_2ff #(
        .RESET_VAL (BUTTON_ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button),
        .q   (button_sync)
    );

    // After synchronisation, 1 always means "button held".
    assign btn_s = BUTTON_ACTIVE_LOW ? ~button_sync : button_sync;

    // Debounce FSM with its counters and registered level/strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= RELEASED;
            deb_cnt_reg       <= '0;
            hold_cnt_reg      <= '0;
            long_done_reg     <= 1'b0;
            pressed_reg       <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
            long_press_reg    <= 1'b0;
        end else begin
            // Strobes last exactly one cycle unless re-asserted below.
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
            long_press_reg    <= 1'b0;

            // Hold time keeps running across release bounces, so the long-press
            // detection is shared by PRESSED and RELEASE_WAIT.
            if ((state_reg == PRESSED) || (state_reg == RELEASE_WAIT)) begin
                if (hold_cnt_reg != HOLD_MAX) begin
                    hold_cnt_reg <= hold_cnt_reg + CNT_ONE;
                end
                if ((hold_cnt_reg == HOLD_LAST) && !long_done_reg) begin
                    long_press_reg <= 1'b1;
                    long_done_reg  <= 1'b1;
                end
            end

            case (state_reg)
                RELEASED: begin
                    if (btn_s) begin
                        state_reg   <= PRESS_WAIT;
                        deb_cnt_reg <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!btn_s) begin
                        // Too short to be a press: treat as bounce.
                        state_reg <= RELEASED;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + CNT_ONE;
                        if (deb_cnt_reg == DEB_LAST) begin
                            state_reg       <= PRESSED;
                            pressed_reg     <= 1'b1;
                            press_pulse_reg <= 1'b1;
                            hold_cnt_reg    <= '0;
                            long_done_reg   <= 1'b0;
                        end
                    end
                end

                PRESSED: begin
                    if (!btn_s) begin
                        state_reg   <= RELEASE_WAIT;
                        deb_cnt_reg <= '0;
                    end
                end

                RELEASE_WAIT: begin
                    if (btn_s) begin
                        // Release bounce: still held, no strobe, long-press state kept.
                        state_reg <= PRESSED;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + CNT_ONE;
                        if (deb_cnt_reg == DEB_LAST) begin
                            state_reg         <= RELEASED;
                            pressed_reg       <= 1'b0;
                            release_pulse_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= RELEASED;
                end
            endcase
        end
    end

    assign pressed       = pressed_reg;
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;
    assign long_press    = long_press_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (active-low pin, 4-cycle debounce,
// 20-cycle long press). A reference model works on run lengths of the
// synchronised pin and on the number of cycles since the accepted press.
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button = 1'b1;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       hist[$];     // pin samples still travelling through the synchroniser
    bit         m_level;     // accepted (debounced) level, 1 = held
    int         m_run;       // consecutive samples disagreeing with m_level
    int         m_since;     // cycles since the last accepted press
    logic [3:0] exp_out;     // {pressed, press_pulse, release_pulse, long_press}
    int         step_no = 0;

    button_debounce #(
        .BUTTON_ACTIVE_LOW (1'b1),
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .CNT_W             (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button        (button),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dut_out();
        return {pressed, press_pulse, release_pulse, long_press};
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b1);
        hist.push_back(1'b1);
        m_level = 1'b0;
        m_run   = 0;
        m_since = 0;
        exp_out = 4'b0000;
    endtask

    // One clock edge of the model: the sample seen by the debouncer is the pin
    // value from two edges earlier; the level flips after D disagreeing samples.
    task automatic model_update(input logic v);
        bit p;
        bit pp, rp, lp;
        hist.push_back(v);
        p = (hist[0] == 1'b0);
        void'(hist.pop_front());
        pp = 1'b0; rp = 1'b0; lp = 1'b0;
        if (m_level) begin
            m_since++;
            if (m_since == L - 1) lp = 1'b1;
        end
        if (p != m_level) m_run++;
        else              m_run = 0;
        if (m_run == D) begin
            if (!m_level) pp = 1'b1;
            else          rp = 1'b1;
            m_level = !m_level;
            m_run   = 0;
            m_since = 0;
        end
        exp_out = {m_level, pp, rp, lp};
    endtask

    // Drive the pin for one cycle, advance the model, and leave time 1 unit
    // after the active edge for sampling.
    task automatic step(input logic v);
        @(negedge clk);
        button = v;
        @(posedge clk);
        if (rst) model_reset();
        else     model_update(v);
        step_no++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 50; i++) begin
            step(1'b1);
            checks++;
            if (dut_out() !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold step %0d: outputs %b, required 0000", i, dut_out());
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            checks++;
            if (dut_out() !== 4'b0000 || dut_out() !== exp_out) begin
                errors++;
                $display("FAIL reset_release step %0d: outputs %b, required 0000", i, dut_out());
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_press_release();
        int press_at = -1, rel_at = -1, n_press = 0, n_rel = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            checks++;
            if (dut_out() !== exp_out) begin
                errors++;
                $display("FAIL press_model step %0d: outputs %b, required %b", i, dut_out(), exp_out);
            end
            if (press_pulse) begin n_press++; press_at = i; end
        end
        checks++;
        if (press_at !== 6 || n_press !== 1 || pressed !== 1'b1) begin
            errors++;
            $display("FAIL press_timing: at %0d count %0d pressed %b, required at 6 count 1 pressed 1",
                     press_at, n_press, pressed);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b1);
            checks++;
            if (dut_out() !== exp_out) begin
                errors++;
                $display("FAIL release_model step %0d: outputs %b, required %b", i, dut_out(), exp_out);
            end
            if (release_pulse) begin n_rel++; rel_at = i; end
        end
        checks++;
        if (rel_at !== 6 || n_rel !== 1 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL release_timing: at %0d count %0d pressed %b, required at 6 count 1 pressed 0",
                     rel_at, n_rel, pressed);
        end
        $display("test_press_release done: press at %0d, release at %0d", press_at, rel_at);
    endtask

    task automatic test_bounce();
        int n_pulse = 0;
        for (int i = 0; i < 40; i++) begin
            step(((i / 2) % 2) ? 1'b1 : 1'b0);
            checks++;
            if (dut_out() !== exp_out || dut_out() !== 4'b0000) begin
                errors++;
                $display("FAIL bounce step %0d: outputs %b, required 0000", i, dut_out());
            end
            if (press_pulse || release_pulse || long_press) n_pulse++;
        end
        for (int i = 0; i < 6; i++) step(1'b1);
        checks++;
        if (n_pulse !== 0) begin
            errors++;
            $display("FAIL bounce_pulses: count %0d, required 0", n_pulse);
        end
        $display("test_bounce done");
    endtask

    task automatic test_glitch();
        int n_press = 0, n_rel = 0;
        bit dropped = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step((i == 11 || i == 12) ? 1'b1 : 1'b0);
            checks++;
            if (dut_out() !== exp_out) begin
                errors++;
                $display("FAIL glitch_model step %0d: outputs %b, required %b", i, dut_out(), exp_out);
            end
            if (press_pulse) n_press++;
            if (release_pulse) n_rel++;
            if (i >= 6 && !pressed) dropped = 1'b1;
        end
        checks++;
        if (n_press !== 1 || n_rel !== 0 || dropped) begin
            errors++;
            $display("FAIL glitch_hold: press %0d release %0d dropped %b, required 1 0 0",
                     n_press, n_rel, dropped);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            checks++;
            if (dut_out() !== exp_out) begin
                errors++;
                $display("FAIL glitch_release step %0d: outputs %b, required %b", i, dut_out(), exp_out);
            end
        end
        $display("test_glitch done");
    endtask

    task automatic test_long_press();
        int press_at = -1, long_at = -1, n_long = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0);
            checks++;
            if (dut_out() !== exp_out) begin
                errors++;
                $display("FAIL long_model step %0d: outputs %b, required %b", i, dut_out(), exp_out);
            end
            if (press_pulse) press_at = i;
            if (long_press) begin n_long++; long_at = i; end
        end
        checks++;
        if (n_long !== 1 || (long_at - press_at) !== L - 1) begin
            errors++;
            $display("FAIL long_timing: count %0d delay %0d, required 1 and %0d",
                     n_long, long_at - press_at, L - 1);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            checks++;
            if (dut_out() !== exp_out || long_press) begin
                errors++;
                $display("FAIL long_after step %0d: outputs %b, required %b", i, dut_out(), exp_out);
            end
        end
        $display("test_long_press done: press at %0d, long at %0d", press_at, long_at);
    endtask

    task automatic test_reset_mid_press();
        int press_at = -1;
        for (int i = 0; i < 10; i++) step(1'b0);
        checks++;
        if (pressed !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup: pressed %b, required 1", pressed);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (dut_out() !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: outputs %b, required 0000", dut_out());
        end
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            checks++;
            if (dut_out() !== exp_out || release_pulse) begin
                errors++;
                $display("FAIL midrst_model step %0d: outputs %b, required %b", i, dut_out(), exp_out);
            end
            if (press_pulse && press_at < 0) press_at = i;
        end
        checks++;
        if (press_at !== 6) begin
            errors++;
            $display("FAIL midrst_repress: press at %0d, required 6", press_at);
        end
        for (int i = 0; i < 10; i++) step(1'b1);
        $display("test_reset_mid_press done: press at %0d", press_at);
    endtask

    task automatic test_random();
        logic v = 1'b1;
        int n_events = 0;
        for (int seg = 0; seg < 120; seg++) begin
            int len;
            v   = ~v;
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(18, 30) : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                step(v);
                checks++;
                if (dut_out() !== exp_out) begin
                    errors++;
                    $display("FAIL random step %0d: outputs %b, required %b", step_no, dut_out(), exp_out);
                end
                if (press_pulse || release_pulse || long_press) n_events++;
            end
        end
        $display("test_random done: %0d strobes observed", n_events);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_release();
        test_bounce();
        test_glitch();
        test_long_press();
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
